uart_parity_unit: RTL

Parametrised parity engine for the UART datapath: generates the transmit parity bit for a parallel frame and checks the received parity of a serial frame bit by bit. It supports even, odd, mark and space parity, runtime data lengths from 1 to DATA_W bits, and a parity-disable mode. TX side feeds the serializer/mux; RX side sits beside the receive deserializer and raises a per-frame parity error.

---
 rtl/uart_par_pkg.sv | 18 +
 rtl/uart_parity_unit_if.sv | 34 +++
 rtl/par_mode_resolve.sv | 22 ++
 rtl/uart_parity_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/uart_par_pkg.sv
// Shared types for the UART parity unit: PAR_TYP encodings and RX checker states.
// No ports; imported by the interface, the resolver and the top level.
package uart_par_pkg;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } par_typ_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/uart_parity_unit_if.sv
// Bus bundle of the UART parity unit: TX capture/parity signals and the RX
// serial check signals. master = datapath driving the unit, slave = the unit.
interface uart_parity_unit_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
);

  logic [DATA_W-1:0] P_DATA;
  logic              Data_Valid;
  logic              busy;
  logic              PAR_EN;
  logic [1:0]        PAR_TYP;
  logic [LEN_W-1:0]  DATA_LEN;
  logic              par_bit;
  logic              rx_start;
  logic              rx_bit_valid;
  logic              rx_bit;
  logic              rx_busy;
  logic              par_err_valid;
  logic              par_err;

  modport master (
    output P_DATA, Data_Valid, busy, PAR_EN, PAR_TYP, DATA_LEN,
    output rx_start, rx_bit_valid, rx_bit,
    input  par_bit, rx_busy, par_err_valid, par_err
  );

  modport slave (
    input  P_DATA, Data_Valid, busy, PAR_EN, PAR_TYP, DATA_LEN,
    input  rx_start, rx_bit_valid, rx_bit,
    output par_bit, rx_busy, par_err_valid, par_err
  );

endinterface

// File: rtl/par_mode_resolve.sv
// Maps a raw XOR reduction plus the parity type to the final parity bit.
// Ports: raw_xor (data XOR), par_typ (parity mode), par_bit_c (resolved bit).
module par_mode_resolve
  import uart_par_pkg::*;
(
  input  logic     raw_xor,
  input  par_typ_t par_typ,
  output logic     par_bit_c
);

  always_comb begin
    par_bit_c = 1'b0;
    unique case (par_typ)
      PAR_EVEN:  par_bit_c = raw_xor;
      PAR_ODD:   par_bit_c = ~raw_xor;
      PAR_MARK:  par_bit_c = 1'b1;
      PAR_SPACE: par_bit_c = 1'b0;
      default:   par_bit_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_parity_unit.sv
// UART parity engine: TX parity generation for a parallel frame and RX
// bit-serial parity checking with a per-frame error pulse.
// Ports: clk, RST (sync, active high), bus (uart_parity_unit_if.slave):
//   TX: P_DATA, Data_Valid, busy, PAR_EN, PAR_TYP, DATA_LEN -> par_bit
//   RX: rx_start, rx_bit_valid, rx_bit -> rx_busy, par_err_valid, par_err
module uart_parity_unit
  import uart_par_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = $clog2(DATA_W + 1)
) (
  input logic                 clk,
  input logic                 RST,
  uart_parity_unit_if.slave   bus
);

  logic [LEN_W-1:0]  eff_len_c;
  logic [DATA_W-1:0] tx_masked_c;
  logic              tx_par_c;
  logic              rx_exp_c;

  rx_state_t         state, state_n;
  logic              acc, acc_n;
  logic [LEN_W-1:0]  cnt, cnt_n;
  par_typ_t          lat_typ, lat_typ_n;
  logic [LEN_W-1:0]  lat_len, lat_len_n;
  logic              par_err_q, par_err_n;
  logic              par_err_valid_q, par_err_valid_n;
  logic              par_bit_q;

  // Length clamp: 0 or anything above DATA_W means a full-width frame
  always_comb begin
    eff_len_c = bus.DATA_LEN;
    if ((bus.DATA_LEN == LEN_W'(0)) || (bus.DATA_LEN > LEN_W'(DATA_W)))
      eff_len_c = LEN_W'(DATA_W);
  end

  // Drop data bits above the active length
  always_comb begin
    tx_masked_c = '0;
    for (int unsigned i = 0; i < DATA_W; i++)
      tx_masked_c[i] = bus.P_DATA[i] & (LEN_W'(i) < eff_len_c);
  end

  par_mode_resolve u_tx_resolve (
    .raw_xor   (^tx_masked_c),
    .par_typ   (par_typ_t'(bus.PAR_TYP)),
    .par_bit_c (tx_par_c)
  );

  par_mode_resolve u_rx_resolve (
    .raw_xor   (acc),
    .par_typ   (lat_typ),
    .par_bit_c (rx_exp_c)
  );

  // TX parity register; captures only when the serializer is free
  always_ff @(posedge clk) begin
    if (RST)
      par_bit_q <= 1'b0;
    else if (bus.Data_Valid && !bus.busy)
      par_bit_q <= bus.PAR_EN ? tx_par_c : 1'b0;
  end

  // RX checker state
  always_ff @(posedge clk) begin
    if (RST) begin
      state           <= IDLE;
      acc             <= 1'b0;
      cnt             <= '0;
      lat_typ         <= PAR_EVEN;
      lat_len         <= '0;
      par_err_q       <= 1'b0;
      par_err_valid_q <= 1'b0;
    end else begin
      state           <= state_n;
      acc             <= acc_n;
      cnt             <= cnt_n;
      lat_typ         <= lat_typ_n;
      lat_len         <= lat_len_n;
      par_err_q       <= par_err_n;
      par_err_valid_q <= par_err_valid_n;
    end
  end

  // RX next state; rx_start overrides everything, including a same-cycle bit
  always_comb begin
    state_n         = state;
    acc_n           = acc;
    cnt_n           = cnt;
    lat_typ_n       = lat_typ;
    lat_len_n       = lat_len;
    par_err_n       = par_err_q;
    par_err_valid_n = 1'b0;

    if (bus.rx_start) begin
      par_err_n = 1'b0;
      if (bus.PAR_EN) begin
        state_n   = DATA;
        acc_n     = 1'b0;
        cnt_n     = '0;
        lat_typ_n = par_typ_t'(bus.PAR_TYP);
        lat_len_n = eff_len_c;
      end else begin
        state_n = IDLE;
      end
    end else begin
      unique case (state)
        DATA: begin
          if (bus.rx_bit_valid) begin
            acc_n = acc ^ bus.rx_bit;
            cnt_n = cnt + LEN_W'(1);
            if ((cnt + LEN_W'(1)) == lat_len)
              state_n = PAR;
          end
        end
        PAR: begin
          if (bus.rx_bit_valid) begin
            par_err_n       = bus.rx_bit ^ rx_exp_c;
            par_err_valid_n = 1'b1;
            state_n         = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.par_bit       = par_bit_q;
  assign bus.rx_busy       = (state != IDLE);
  assign bus.par_err_valid = par_err_valid_q;
  assign bus.par_err       = par_err_q;

endmodule
